dmem_responder: RTL and testbench

//  Data-memory slave answering load/store requests issued by the execute stage (EX/MEM request side).

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 97 +++++++++
 tb/tb_dmem_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the execute stage (master) and the data memory (slave)
//   request : req_valid, req_is_load, req_is_store, req_addr, req_wdata, req_funct3 / req_ready
//   response: DATAI, rsp_valid, HLT, err_misalign, err_range
interface dmem_responder_if;
  logic        req_valid;
  logic        req_is_load;
  logic        req_is_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready;
  logic [31:0] DATAI;
  logic        rsp_valid;
  logic        HLT;
  logic        err_misalign;
  logic        err_range;
  modport master(
    output req_valid, req_is_load, req_is_store, req_addr, req_wdata, req_funct3,
    input  req_ready, DATAI, rsp_valid, HLT, err_misalign, err_range
  );
  modport slave(
    input  req_valid, req_is_load, req_is_store, req_addr, req_wdata, req_funct3,
    output req_ready, DATAI, rsp_valid, HLT, err_misalign, err_range
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory answering EX/MEM load/store requests with optional wait states
//   CLK         rising-edge clock
//   RES         synchronous active-low reset
//   bus (slave) request req_valid/req_is_load/req_is_store/req_addr/req_wdata/req_funct3, accept req_ready;
//               response DATAI/rsp_valid, stall HLT, error pulses err_misalign/err_range
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input logic          CLK,
  input logic          RES,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WLOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q, size_q;
  logic [31:0]   wdata_q, data_q;
  logic          load_q, err_m_q, err_r_q;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   off, rd_data, wr_data;
  logic [3:0]    be;
  logic          one, mis, rng, take, accept, err_m_d, err_r_d, ready, rsp;
  always_comb begin
    off = bus.req_addr - BASE_ADDR;
    one = bus.req_is_load ^ bus.req_is_store;
    // funct3 011/110/111 are treated as misaligned
    mis = bus.req_funct3 inside {3'b000, 3'b100} ? 1'b0 :
          bus.req_funct3 inside {3'b001, 3'b101} ? bus.req_addr[0] :
          bus.req_funct3 == 3'b010 ? |bus.req_addr[1:0] : 1'b1;
    rng = (bus.req_addr < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH_WORDS));
    take = ready && bus.req_valid;
    accept = take && one && !mis && !rng;
    err_m_d = take && one && mis;
    err_r_d = take && ((bus.req_is_load && bus.req_is_store) || (one && rng));
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = cnt_q == 4'd0 ? RESP : WAIT;
    end else begin
      cnt_d = WLOAD;
      state_d = accept ? (WAIT_CYCLES > 0 ? WAIT : RESP) : IDLE;
    end
  end
  assign ready = state_q != WAIT;
  assign rsp = state_q == RESP && load_q;
  // RAM is read during RESP, so a store committed at the previous edge is already visible
  assign rd_data = mem[idx_q] >> {lane_q, 3'b000};
  assign be = size_q == 2'd0 ? 4'b0001 << lane_q :
              size_q == 2'd1 ? 4'b0011 << {lane_q[1], 1'b0} : 4'b1111;
  assign wr_data = size_q == 2'd0 ? {4{wdata_q[7:0]}} :
                   size_q == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
  assign bus.req_ready = ready;
  assign bus.HLT = state_q == WAIT;
  assign bus.rsp_valid = rsp;
  assign bus.DATAI = rsp ? rd_data : data_q;
  assign bus.err_misalign = err_m_q;
  assign bus.err_range = err_r_q;
  always_ff @(posedge CLK) begin
    if (!RES) begin
      state_q <= IDLE;
      cnt_q <= '0;
      data_q <= '0;
      err_m_q <= 1'b0;
      err_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_m_q <= err_m_d;
      err_r_q <= err_r_d;
      if (rsp) data_q <= rd_data;
      if (err_m_d || err_r_d) data_q <= '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (accept) begin
      idx_q <= off[AW+1:2];
      lane_q <= off[1:0];
      size_q <= bus.req_funct3[1:0];
      wdata_q <= bus.req_wdata;
      load_q <= bus.req_is_load;
    end
  end
  // a store pending when reset arrives is dropped
  always_ff @(posedge CLK) begin
    if (RES && state_q == RESP && !load_q)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx_q][8*b +: 8] <= wr_data[8*b +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (0, 2, 3 wait states) driven in parallel, checked against a byte-level model
module tb_dmem_responder;
  localparam int DEPTH = 64;
  localparam int NB = 4 * DEPTH;
  localparam logic [31:0] BASE = 32'h8000_0000;
  logic CLK = 1'b0;
  logic RES = 1'b0;
  logic valid, ld, st;
  logic [31:0] addr, wdata;
  logic [2:0] f3;
  logic rdy [3], hlt [3], rsp [3], em [3], er [3];
  logic [31:0] dat [3];
  int vecs = 0, errs = 0;
  int nh [3], nr [3], nm [3], ne [3];
  bit pend [3], pl [3];
  int left [3], po [3];
  logic [31:0] pw [3];
  logic [2:0] pf [3];
  logic [7:0] mb [3][NB];
  bit e_rdy [3] = '{1, 1, 1};
  bit e_hlt [3], e_rsp [3], e_em [3], e_er [3];
  logic [31:0] e_dat [3] = '{0, 0, 0};
  always #5 CLK = ~CLK;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder_if ifc();
    assign ifc.req_valid = valid;
    assign ifc.req_is_load = ld;
    assign ifc.req_is_store = st;
    assign ifc.req_addr = addr;
    assign ifc.req_wdata = wdata;
    assign ifc.req_funct3 = f3;
    assign rdy[g] = ifc.req_ready;
    assign hlt[g] = ifc.HLT;
    assign rsp[g] = ifc.rsp_valid;
    assign em[g] = ifc.err_misalign;
    assign er[g] = ifc.err_range;
    assign dat[g] = ifc.DATAI;
    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(g == 0 ? 0 : g + 1)) dut (
      .CLK(CLK), .RES(RES), .bus(ifc.slave)
    );
  end
  function automatic int wc(int i);
    return i == 0 ? 0 : i + 1;
  endfunction
  function automatic int sz(logic [2:0] f);
    return f[1:0] == 2'd0 ? 1 : f[1:0] == 2'd1 ? 2 : 4;
  endfunction
  function automatic bit misal(logic [31:0] a, logic [2:0] f);
    if (f == 3'b000 || f == 3'b100) return 1'b0;
    if (f == 3'b001 || f == 3'b101) return a % 2 != 0;
    if (f == 3'b010) return a % 4 != 0;
    return 1'b1;
  endfunction
  function automatic bit outr(logic [31:0] a);
    return a < BASE || (a - BASE) >= 32'(NB);
  endfunction
  // transaction-level reference: a pending access counts down its stall cycles, then responds for one cycle
  always @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      e_em[i] = 0; e_er[i] = 0; e_rsp[i] = 0;
      if (!RES) begin
        pend[i] = 0; left[i] = 0; e_dat[i] = 0;
      end else if (pend[i] && left[i] > 0) begin
        left[i]--;
      end else begin
        if (pend[i] && !pl[i])
          for (int k = 0; k < sz(pf[i]); k++) mb[i][po[i] + k] = pw[i][8*k +: 8];
        pend[i] = 0;
        if (valid && (ld ^ st)) begin
          if (misal(addr, f3) || outr(addr)) begin
            e_em[i] = misal(addr, f3); e_er[i] = outr(addr); e_dat[i] = 0;
          end else begin
            pend[i] = 1; left[i] = wc(i); pl[i] = ld; po[i] = int'(addr - BASE); pw[i] = wdata; pf[i] = f3;
          end
        end else if (valid && ld && st) begin
          e_er[i] = 1; e_dat[i] = 0;
        end
      end
      if (pend[i] && left[i] == 0 && pl[i]) begin
        int b;
        b = po[i] - po[i] % 4;
        e_rsp[i] = 1;
        e_dat[i] = {mb[i][b+3], mb[i][b+2], mb[i][b+1], mb[i][b]} >> (8 * (po[i] % 4));
      end
      e_hlt[i] = pend[i] && left[i] > 0;
      e_rdy[i] = !e_hlt[i];
    end
  end
  task automatic chk(string n, int i, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d] t=%0t got %h want %h", n, i, $time, act, exp);
    end
  endtask
  task automatic step();
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      chk("req_ready", i, rdy[i], e_rdy[i]);
      chk("HLT", i, hlt[i], e_hlt[i]);
      chk("rsp_valid", i, rsp[i], e_rsp[i]);
      chk("err_misalign", i, em[i], e_em[i]);
      chk("err_range", i, er[i], e_er[i]);
      chk("DATAI", i, dat[i], e_dat[i]);
      nh[i] += int'(hlt[i]); nr[i] += int'(rsp[i]); nm[i] += int'(em[i]); ne[i] += int'(er[i]);
    end
  endtask
  task automatic txn(bit l, bit s, logic [31:0] a, logic [31:0] d, logic [2:0] f);
    for (int i = 0; i < 3; i++) begin
      nh[i] = 0; nr[i] = 0; nm[i] = 0; ne[i] = 0;
    end
    valid = 1; ld = l; st = s; addr = a; wdata = d; f3 = f;
    step();
    valid = 0; ld = 0; st = 0;
    repeat (5) step();
  endtask
  initial begin
    int k;
    valid = 0; ld = 0; st = 0; addr = BASE; wdata = 0; f3 = 0;
    repeat (2) step();
    RES = 1;
    for (int w = 0; w < DEPTH; w++) txn(0, 1, BASE + 32'(4 * w), $urandom, 3'b010);
    txn(0, 1, BASE + 32'h10, 32'hDEADBEEF, 3'b010);
    txn(1, 0, BASE + 32'h10, 0, 3'b010);
    for (int i = 0; i < 3; i++) begin
      chk("t1_lw", i, dat[i], 32'hDEADBEEF);
      chk("t1_rsp_count", i, nr[i], 1);
      chk("t5_hlt_count", i, nh[i], wc(i));
    end
    txn(0, 1, BASE + 32'h10, 32'h11223344, 3'b010);
    txn(0, 1, BASE + 32'h12, 32'h123456AA, 3'b000);
    txn(1, 0, BASE + 32'h10, 0, 3'b010);
    for (int i = 0; i < 3; i++) chk("t2_lw", i, dat[i], 32'h11AA3344);
    txn(1, 0, BASE + 32'h12, 0, 3'b100);
    for (int i = 0; i < 3; i++) chk("t2_lbu", i, dat[i], 32'h000011AA);
    txn(0, 1, BASE + 32'h14, 32'hCAFE1234, 3'b010);
    txn(1, 0, BASE + 32'h16, 0, 3'b001);
    for (int i = 0; i < 3; i++) chk("t3_lh", i, dat[i], 32'h0000CAFE);
    txn(1, 0, BASE + 32'h11, 0, 3'b010);
    for (int i = 0; i < 3; i++) begin
      chk("t3_misalign_count", i, nm[i], 1);
      chk("t3_no_rsp", i, nr[i], 0);
      chk("t3_no_hlt", i, nh[i], 0);
      chk("t3_datai_cleared", i, dat[i], 0);
    end
    txn(0, 1, BASE, 32'h0BADF00D, 3'b010);
    txn(0, 1, BASE + 32'(NB - 4), 32'h600DCAFE, 3'b010);
    txn(0, 1, 32'h7FFF_FFFC, 32'hFFFFFFFF, 3'b010);
    for (int i = 0; i < 3; i++) chk("t4_range_low", i, ne[i], 1);
    txn(0, 1, BASE + 32'(NB), 32'hFFFFFFFF, 3'b010);
    for (int i = 0; i < 3; i++) chk("t4_range_high", i, ne[i], 1);
    txn(1, 1, BASE, 32'hFFFFFFFF, 3'b010);
    for (int i = 0; i < 3; i++) chk("t4_both_strobes", i, ne[i], 1);
    txn(1, 0, BASE, 0, 3'b010);
    for (int i = 0; i < 3; i++) chk("t4_word0", i, dat[i], 32'h0BADF00D);
    txn(1, 0, BASE + 32'(NB - 4), 0, 3'b010);
    for (int i = 0; i < 3; i++) chk("t4_wordlast", i, dat[i], 32'h600DCAFE);
    txn(0, 1, BASE + 32'h20, 32'h11111111, 3'b010);
    for (int i = 0; i < 3; i++) begin
      nh[i] = 0; nr[i] = 0; nm[i] = 0; ne[i] = 0;
    end
    valid = 1; ld = 0; st = 1; addr = BASE + 32'h20; wdata = 32'h22222222; f3 = 3'b010;
    step();
    valid = 0; st = 0;
    step();
    RES = 0;
    step();
    RES = 1;
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_err", i, nm[i] + ne[i], 0);
      chk("t6_no_rsp", i, nr[i], 0);
    end
    txn(1, 0, BASE + 32'h20, 0, 3'b010);
    for (int i = 0; i < 3; i++) chk("t6_readback", i, dat[i], i == 0 ? 32'h22222222 : 32'h11111111);
    for (int c = 0; c < 3000; c++) begin
      RES = $urandom_range(0, 199) != 0;
      valid = $urandom_range(0, 4) != 0;
      k = $urandom_range(0, 19);
      ld = k == 1 || (k >= 2 && k < 11);
      st = k == 1 || k >= 11;
      k = $urandom_range(0, 19);
      addr = k == 0 ? BASE - 32'($urandom_range(1, 16)) :
             k == 1 ? BASE + 32'(NB) + 32'($urandom_range(0, 15)) : BASE + 32'($urandom_range(0, NB - 1));
      k = $urandom_range(0, 9);
      f3 = k < 8 ? (k < 2 ? 3'b000 : k < 4 ? 3'b001 : k < 6 ? 3'b010 : k == 6 ? 3'b100 : 3'b101) : 3'($urandom);
      wdata = $urandom;
      step();
    end
    RES = 1; valid = 0; ld = 0; st = 0;
    repeat (5) step();
    for (int w = 0; w < DEPTH; w++) txn(1, 0, BASE + 32'(4 * w), 0, 3'b010);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
